mips_cpu_muldiv: RTL and testbench

Iterative HI/LO multiply/divide unit for the MIPS core. It sits directly downstream of the register file and consumes the rs/rt read values. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in internal HI/LO registers. These registers are read by MFHI/MFLO and written by MTHI/MTLO.

---
 rtl/mips_cpu_muldiv_pkg.sv | 22 ++
 rtl/mips_cpu_div_step.sv | 21 ++
 rtl/mips_cpu_muldiv.sv | 150 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  localparam int unsigned MAX_W = 64;

  // Quotient reported for a zero divisor; truncated to the datapath width.
  localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-divide step: shift in a dividend bit, subtract if it fits.
module mips_cpu_div_step
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem_c,
  output logic             o_qbit_c
);

  logic [WIDTH:0] w_shift;

  assign w_shift  = {i_rem, i_bit};
  assign o_qbit_c = (w_shift >= {1'b0, i_div});
  // Partial remainder stays below the divisor, so the low WIDTH bits always suffice.
  assign o_rem_c  = o_qbit_c ? WIDTH'(w_shift - {1'b0, i_div}) : WIDTH'(w_shift);

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MIPS_MULDIV_FAST_MULT_EN for a single-cycle multiply path (IDLE -> FIX).
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_md;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  op_t              w_op;
  logic             w_signed;
  logic             w_is_div;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_abs_rs;
  logic [WIDTH-1:0] w_abs_rt;
  logic [WIDTH-1:0] w_rem_c;
  logic             w_qbit_c;
  logic [WIDTH:0]   w_msum;
  logic [PW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_op     = op_t'(op);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_rs_neg = w_signed & rs[WIDTH-1];
  assign w_rt_neg = w_signed & rt[WIDTH-1];
  assign w_abs_rs = w_rs_neg ? -rs : rs;
  assign w_abs_rt = w_rt_neg ? -rt : rt;

  // r_p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  assign w_msum = {1'b0, r_p[PW-1:WIDTH]} + {1'b0, (r_p[0] ? r_md : WIDTH'(0))};
  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_quot = r_p[WIDTH-1:0];
  assign w_rem  = r_p[PW-1:WIDTH];

  mips_cpu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem    (r_p[PW-1:WIDTH]),
    .i_bit    (r_p[WIDTH-1]),
    .i_div    (r_md),
    .o_rem_c  (w_rem_c),
    .o_qbit_c (w_qbit_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_md     <= '0;
      r_p      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= w_is_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_div0   <= w_is_div && (rt == '0);
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_busy   <= 1'b1;
            if (w_is_div) begin
              r_md    <= w_abs_rt;
              r_p     <= {WIDTH'(0), w_abs_rs};
              r_state <= S_RUN;
            end else begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
              r_md    <= w_abs_rs;
              r_p     <= PW'(w_abs_rs) * PW'(w_abs_rt);
              r_state <= S_FIX;
`else
              r_md    <= w_abs_rs;
              r_p     <= {WIDTH'(0), w_abs_rt};
              r_state <= S_RUN;
`endif
            end
          end else begin
            if (mthi) r_hi <= wd;
            if (mtlo) r_lo <= wd;
          end
        end
        S_RUN: begin
          if (r_is_div) r_p <= {w_rem_c, r_p[WIDTH-2:0], w_qbit_c};
          else          r_p <= {w_msum, r_p[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          // Remainder follows the dividend's sign; a zero divisor leaves |rs| re-signed, i.e. raw rs.
          if (r_is_div) begin
            r_hi <= r_neg_r ? -w_rem : w_rem;
            r_lo <= r_div0 ? WIDTH'(DIV0_QUOT) : (r_neg_q ? -w_quot : w_quot);
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv (honours MIPS_MULDIV_FAST_MULT_EN).
module tb_mips_cpu_muldiv;

`ifdef MIPS_MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  mips_cpu_muldiv #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait for done, and check latency and HI/LO.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit with_mt);
    int cyc;
    int lat;
    lat = (FAST && !o[1]) ? 2 : 34;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    if (with_mt) begin
      mthi = 1'b1; mtlo = 1'b1; wd = 32'h5555_5555;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
    mthi = 1'b0; mtlo = 1'b0; wd = '0;
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negrt", 2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div_neg0",  2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // MTHI in IDLE
    @(negedge clk);
    mthi = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo_kept", lo, 32'h8000_0000);

    // MTLO and a second start while busy are ignored
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    @(negedge clk);
    cyc++;
    mtlo = 1'b1; wd = 32'hDEAD_BEEF; start = 1'b1; op = 2'b01; rs = 32'd5; rt = 32'd5;
    @(negedge clk);
    cyc++;
    mtlo = 1'b0; start = 1'b0;
    check("busy_ign_hi", hi, 32'h0000_1234);
    check("busy_ign_lo", lo, 32'h8000_0000);
    check("busy_ign_busy", 32'(busy), 32'd1);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_ign_latency", 32'(cyc), 32'd34);
    check("busy_ign_res_hi", hi, 32'd2);
    check("busy_ign_res_lo", lo, 32'd14);
    @(negedge clk);
    check("no_queue_busy", 32'(busy), 32'd0);
    check("no_queue_done", 32'(done), 32'd0);

    // MTHI and MTLO together
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wd = 32'hA5A5_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'hA5A5_0F0F);
    check("mt_both_lo", lo, 32'hA5A5_0F0F);

    // start beats MTHI/MTLO in the same cycle
    run_op("start_wins", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b1);

    // Async reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'hFFFF_FFFF; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    run_op("after_rst", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
